// File: rtl/floor_request_scheduler.sv
// -----------------------------------------------------------------------------
// floor_request_scheduler
//
// Upstream stage of the elevator controller. Raw call buttons are
// synchronized, debounced and latched as pending requests. The next target
// floor is chosen with SCAN ordering: keep serving in the current direction
// while requests remain that way, then reverse.
//
// Optional build macro: REQ_CANCEL_EN
//   When defined, a fresh press on a floor that is already pending (and is
//   not the current floor) cancels that request instead of being ignored.
//
// Ports:
//   clk              clock
//   reset            asynchronous, active-high reset
//   call_btn         raw asynchronous call buttons, bit i = floor i
//   current_floor    floor reported by the controller
//   at_floor         controller is stopped at current_floor
//   requested_floor  registered target floor sent to the controller
//   req_valid        high while serving up or down
//   pending          latched outstanding requests
//   dir_up           last/active scan direction, 1 = up
// -----------------------------------------------------------------------------
module floor_request_scheduler #(
    parameter int NUM_FLOORS      = 10,
    parameter int FLOOR_W         = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  at_floor,
    output logic [FLOOR_W-1:0]    requested_floor,
    output logic                  req_valid,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up
);

    // Counter only has to reach DEBOUNCE_CYCLES-1; the sample that would
    // take it to DEBOUNCE_CYCLES flips the debounced level instead.
    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SERVE_UP,
        S_SERVE_DOWN
    } state_t;

    logic [NUM_FLOORS-1:0] r_sync1;
    logic [NUM_FLOORS-1:0] r_sync2;
    logic [NUM_FLOORS-1:0] r_deb;
    logic [CNT_W-1:0]      r_cnt [NUM_FLOORS];
    logic [NUM_FLOORS-1:0] r_pending;
    state_t                r_state;
    logic [FLOOR_W-1:0]    r_requested_floor;
    logic                  r_req_valid;
    logic                  r_dir_up;

    logic [NUM_FLOORS-1:0] w_flip;
    logic [NUM_FLOORS-1:0] w_press;
    logic [NUM_FLOORS-1:0] w_is_cur;
    logic [NUM_FLOORS-1:0] w_above;
    logic [NUM_FLOORS-1:0] w_below;
    logic [NUM_FLOORS-1:0] w_pending_next;
    logic [FLOOR_W-1:0]    w_up_target;
    logic [FLOOR_W-1:0]    w_down_target;
    logic [FLOOR_W-1:0]    w_next_target;
    logic                  w_next_dir;
    logic                  w_any_above;
    logic                  w_any_below;
    state_t                w_next_state;

    // -------------------------------------------------------------------------
    // Two-flop synchronizer
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, which is what makes the two
    // synchronizer stages a real two-cycle delay.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= call_btn;
            r_sync2 <= r_sync1;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce: the level flips on the DEBOUNCE_CYCLES-th consecutive
    // synchronized sample that disagrees with it. The press pulse is asserted
    // in that same cycle so pending sets together with the debounced level.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_flip[i]  = (r_sync2[i] != r_deb[i]) && (r_cnt[i] == CNT_LAST);
            w_press[i] = w_flip[i] && r_sync2[i];
        end
    end

    // NOTE: the per-bit counter array is ordinary flops, not a RAM, so it is
    // cleared on reset like every other register here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_deb <= '0;
            for (int i = 0; i < NUM_FLOORS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_flip[i]) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pending requests. An out-of-range current_floor matches no bit, so it
    // clears nothing. Clearing at the current floor beats a same-cycle set.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_is_cur[i] = (int'(current_floor) == i);
        end
`ifdef REQ_CANCEL_EN
        w_pending_next = ((r_pending | w_press) & ~(w_press & r_pending & ~w_is_cur))
                         & ~({NUM_FLOORS{at_floor}} & w_is_cur);
`else
        w_pending_next = (r_pending | w_press) & ~({NUM_FLOORS{at_floor}} & w_is_cur);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // -------------------------------------------------------------------------
    // Candidate sets and nearest target in each direction
    // -------------------------------------------------------------------------
    // NOTE: every signal written in a combinational block gets a default at
    // the top, so no path through the loops or the case can infer a latch.
    always_comb begin
        w_above       = '0;
        w_below       = '0;
        w_up_target   = '0;
        w_down_target = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_above[i] = r_pending[i] && (i > int'(current_floor));
            w_below[i] = r_pending[i] && (i < int'(current_floor));
        end
        // Descending scan leaves the lowest set index in above.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (w_above[i]) begin
                w_up_target = FLOOR_W'(i);
            end
        end
        // Ascending scan leaves the highest set index in below.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (w_below[i]) begin
                w_down_target = FLOOR_W'(i);
            end
        end
    end

    assign w_any_above = |w_above;
    assign w_any_below = |w_below;

    // -------------------------------------------------------------------------
    // SCAN state machine: next state, then target/direction for that state
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state  = r_state;
        w_next_target = current_floor;
        w_next_dir    = r_dir_up;

        case (r_state)
            S_IDLE: begin
                // With work on both sides, resume the last direction.
                if (w_any_above && (r_dir_up || !w_any_below)) begin
                    w_next_state = S_SERVE_UP;
                end else if (w_any_below) begin
                    w_next_state = S_SERVE_DOWN;
                end
            end
            S_SERVE_UP: begin
                if (w_any_above) begin
                    w_next_state = S_SERVE_UP;
                end else if (w_any_below) begin
                    w_next_state = S_SERVE_DOWN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_SERVE_DOWN: begin
                if (w_any_below) begin
                    w_next_state = S_SERVE_DOWN;
                end else if (w_any_above) begin
                    w_next_state = S_SERVE_UP;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        case (w_next_state)
            S_SERVE_UP: begin
                w_next_target = w_up_target;
                w_next_dir    = 1'b1;
            end
            S_SERVE_DOWN: begin
                w_next_target = w_down_target;
                w_next_dir    = 1'b0;
            end
            default: begin
                // Idle target equals the current floor so the controller holds.
                w_next_target = current_floor;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_requested_floor <= '0;
            r_req_valid       <= 1'b0;
            r_dir_up          <= 1'b1;
        end else begin
            r_state           <= w_next_state;
            r_requested_floor <= w_next_target;
            r_req_valid       <= (w_next_state != S_IDLE);
            r_dir_up          <= w_next_dir;
        end
    end

    assign requested_floor = r_requested_floor;
    assign req_valid       = r_req_valid;
    assign pending         = r_pending;
    assign dir_up          = r_dir_up;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// -----------------------------------------------------------------------------
// tb_floor_request_scheduler
//
// Self-checking bench for floor_request_scheduler. A behavioural model tracks
// debounced presses with a sliding window over the synchronized sample
// history, and chooses targets directly from the SCAN rule. Directed
// scenarios come first, then a long randomized run with occasional resets.
// Define REQ_CANCEL_EN for both bench and design to cover the cancel build.
// -----------------------------------------------------------------------------
module tb_floor_request_scheduler;

    localparam int NF = 10;
    localparam int FW = 4;
    localparam int DC = 4;

    logic          clk;
    logic          reset;
    logic [NF-1:0] call_btn;
    logic [FW-1:0] current_floor;
    logic          at_floor;
    logic [FW-1:0] requested_floor;
    logic          req_valid;
    logic [NF-1:0] pending;
    logic          dir_up;

    floor_request_scheduler #(
        .NUM_FLOORS      (NF),
        .FLOOR_W         (FW),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .call_btn        (call_btn),
        .current_floor   (current_floor),
        .at_floor        (at_floor),
        .requested_floor (requested_floor),
        .req_valid       (req_valid),
        .pending         (pending),
        .dir_up          (dir_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    logic [NF-1:0] m_pend;
    logic          m_valid;
    logic          m_dir;
    logic [FW-1:0] m_req;
    logic [NF-1:0] m_deb;
    int            m_flip [NF];
    logic [NF-1:0] raw_q  [$];
    logic [NF-1:0] samp_q [$];

    task automatic model_reset();
        m_pend  = '0;
        m_valid = 1'b0;
        m_dir   = 1'b1;
        m_req   = '0;
        m_deb   = '0;
        for (int b = 0; b < NF; b++) m_flip[b] = 0;
        raw_q.delete();
        samp_q.delete();
    endtask

    // Advances the model across the next rising edge using the inputs that
    // are currently applied.
    task automatic model_step();
        int            cf;
        int            lo;
        int            hi;
        int            n;
        bit            above;
        bit            below;
        bit            all_diff;
        logic [NF-1:0] press;
        logic [NF-1:0] s;
        logic [NF-1:0] past;

        // SCAN decision from pre-edge pending and current floor.
        cf    = int'(current_floor);
        above = 1'b0;
        below = 1'b0;
        lo    = -1;
        hi    = -1;
        for (int i = 0; i < NF; i++) begin
            if (m_pend[i] && i > cf) begin
                above = 1'b1;
                if (lo < 0) lo = i;
            end
            if (m_pend[i] && i < cf) begin
                below = 1'b1;
                hi    = i;
            end
        end
        if ((m_dir && above) || (!m_dir && !below && above)) begin
            m_valid = 1'b1;
            m_dir   = 1'b1;
            m_req   = FW'(lo);
        end else if (below) begin
            m_valid = 1'b1;
            m_dir   = 1'b0;
            m_req   = FW'(hi);
        end else begin
            m_valid = 1'b0;
            m_req   = current_floor;
        end

        // Synchronized sample seen this edge is the raw value from two edges ago.
        raw_q.push_back(call_btn);
        n = raw_q.size();
        s = (n >= 3) ? raw_q[n - 3] : '0;
        samp_q.push_back(s);

        press = '0;
        for (int b = 0; b < NF; b++) begin
            if (n - m_flip[b] >= DC) begin
                all_diff = 1'b1;
                for (int j = 0; j < DC; j++) begin
                    past = samp_q[n - 1 - j];
                    if (past[b] == m_deb[b]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_deb[b]  = ~m_deb[b];
                    m_flip[b] = n;
                    if (m_deb[b]) press[b] = 1'b1;
                end
            end
        end

        for (int i = 0; i < NF; i++) begin
            if (at_floor && cf == i) begin
                m_pend[i] = 1'b0;
            end else if (press[i]) begin
`ifdef REQ_CANCEL_EN
                m_pend[i] = (m_pend[i] && cf != i) ? 1'b0 : 1'b1;
`else
                m_pend[i] = 1'b1;
`endif
            end
        end
    endtask

    task automatic compare_all();
        check("pending",         32'(pending),         32'(m_pend));
        check("requested_floor", 32'(requested_floor), 32'(m_req));
        check("req_valid",       32'(req_valid),       32'(m_valid));
        check("dir_up",          32'(dir_up),          32'(m_dir));
    endtask

    // Called at a falling edge: apply inputs, let one rising edge pass,
    // compare at the next falling edge.
    task automatic step(input logic [NF-1:0] btn, input logic [FW-1:0] cf, input logic af);
        call_btn      = btn;
        current_floor = cf;
        at_floor      = af;
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("reset_pending",   32'(pending),         32'd0);
        check("reset_requested", 32'(requested_floor), 32'd0);
        check("reset_req_valid", 32'(req_valid),       32'd0);
        check("reset_dir_up",    32'(dir_up),          32'd1);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------- stimulus
    logic [NF-1:0] r_btn;
    logic [FW-1:0] r_cf;
    logic          r_af;
    logic [NF-1:0] b3;
    logic [NF-1:0] b7;
    logic [NF-1:0] b8;
    logic [NF-1:0] b35;

    initial begin
        b3  = '0; b3[3] = 1'b1;
        b7  = '0; b7[7] = 1'b1;
        b8  = '0; b8[8] = 1'b1;
        b35 = b3; b35[5] = 1'b1;

        call_btn      = '0;
        current_floor = '0;
        at_floor      = 1'b0;
        reset         = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Reset in the middle of serving up toward floor 5 (pending 3 and 5).
        for (int k = 0; k < 8; k++) step(b35, 4'd4, 1'b0);
        check("mid_pending",   32'(pending),         32'h028);
        check("mid_requested", 32'(requested_floor), 32'd5);
        check("mid_req_valid", 32'(req_valid),       32'd1);
        step('0, 4'd4, 1'b0);
        do_reset();
        step('0, 4'd4, 1'b0);
        check("post_reset_requested", 32'(requested_floor), 32'd4);
        check("post_reset_req_valid", 32'(req_valid),       32'd0);

        // Glitch shorter than the debounce window is ignored.
        for (int k = 0; k < 3; k++) step(b7, 4'd0, 1'b1);
        for (int k = 0; k < 10; k++) step('0, 4'd0, 1'b1);
        check("glitch_pending", 32'(pending), 32'd0);

        // Held press: pending after 6 edges, target one edge later.
        for (int k = 1; k <= 20; k++) begin
            step(b7, 4'd0, 1'b1);
            if (k == 5) check("press_latency_early", 32'(pending[7]), 32'd0);
            if (k == 6) check("press_latency",       32'(pending[7]), 32'd1);
            if (k == 7) begin
                check("press_target",    32'(requested_floor), 32'd7);
                check("press_req_valid", 32'(req_valid),       32'd1);
                check("press_dir_up",    32'(dir_up),          32'd1);
            end
        end
        for (int k = 0; k < 8; k++) step('0, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) step('0, 4'd7, 1'b1);
        check("serviced_pending", 32'(pending), 32'd0);

        // Press at the floor where the car is stopped: clear wins.
        for (int k = 0; k < 10; k++) begin
            step(b3, 4'd3, 1'b1);
            check("clear_wins_pending", 32'(pending[3]), 32'd0);
        end
        check("clear_wins_requested", 32'(requested_floor), 32'd3);
        check("clear_wins_req_valid", 32'(req_valid),       32'd0);
        for (int k = 0; k < 8; k++) step('0, 4'd3, 1'b1);

        // Re-press of an already pending floor.
        for (int k = 0; k < 8; k++) step(b8, 4'd2, 1'b0);
        for (int k = 0; k < 8; k++) step('0, 4'd2, 1'b0);
        check("repress_before", 32'(pending[8]), 32'd1);
        for (int k = 0; k < 8; k++) step(b8, 4'd2, 1'b0);
`ifdef REQ_CANCEL_EN
        check("cancel_pending",   32'(pending),         32'd0);
        check("cancel_requested", 32'(requested_floor), 32'd2);
        check("cancel_req_valid", 32'(req_valid),       32'd0);
`else
        check("repress_pending",   32'(pending[8]),      32'd1);
        check("repress_requested", 32'(requested_floor), 32'd8);
`endif
        for (int k = 0; k < 8; k++) step('0, 4'd2, 1'b0);

        // Randomized run: the car drifts toward the model's target, sometimes
        // jumps (including out-of-range floors), buttons bounce.
        r_btn = '0;
        r_cf  = 4'd2;
        for (int t = 0; t < 4000; t++) begin
            for (int b = 0; b < NF; b++) begin
                if ($urandom_range(0, 15) == 0) r_btn[b] = ~r_btn[b];
            end
            if ($urandom_range(0, 63) == 0) begin
                r_cf = FW'($urandom_range(0, 15));
            end else if ($urandom_range(0, 3) == 0) begin
                if (r_cf < m_req) r_cf = r_cf + 4'd1;
                else if (r_cf > m_req) r_cf = r_cf - 4'd1;
            end
            if (r_cf == m_req) r_af = ($urandom_range(0, 3) != 0);
            else               r_af = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end
            step(r_btn, r_cf, r_af);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
